// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, reorder bank states and bit-reversal helper
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_W     = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Also used by the FFT core's address generator: pair index -> lower-half bin.
    function automatic logic [FFT_LOG2N-2:0] bitrev5(input logic [FFT_LOG2N-2:0] idx);
        logic [FFT_LOG2N-2:0] rev;
        for (int b = 0; b < FFT_LOG2N - 1; b++) begin
            rev[b] = idx[FFT_LOG2N-2-b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - one frame of storage: lower/upper half register files,
// both written in the same cycle, read combinationally by natural bin index.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [FFT_LOG2N-2:0]   wr_addr,
    input  logic [2*W-1:0]         wr_data0,
    input  logic [2*W-1:0]         wr_data1,
    input  logic [FFT_LOG2N-1:0]   rd_addr,
    output logic [2*W-1:0]         rd_data
);

    localparam int HALF = FFT_N / 2;

    logic [2*W-1:0] lo_mem_q [HALF];
    logic [2*W-1:0] hi_mem_q [HALF];

    // Contents are don't-care after reset, so the arrays carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lo_mem_q[wr_addr] <= wr_data0;
            hi_mem_q[wr_addr] <= wr_data1;
        end
    end

    assign rd_data = rd_addr[FFT_LOG2N-1] ? hi_mem_q[rd_addr[FFT_LOG2N-2:0]]
                                          : lo_mem_q[rd_addr[FFT_LOG2N-2:0]];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder of bit-reversed FFT pairs into a
// natural-order, one-bin-per-cycle valid/ready stream with drop/abort flags.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int W = FFT_W,
    parameter int N = FFT_N
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    input  logic         in_start,
    input  logic [W-1:0] inReal0,
    input  logic [W-1:0] inImag0,
    input  logic [W-1:0] inReal1,
    input  logic [W-1:0] inImag1,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] outReal,
    output logic [W-1:0] outImag,
    output logic         out_first,
    output logic         out_last,
    output logic         frame_drop,
    output logic         frame_abort
);

    localparam int PW = FFT_LOG2N - 1;
    localparam int BW = FFT_LOG2N;
    localparam logic [PW-1:0] LAST_PAIR = PW'(N / 2 - 1);
    localparam logic [BW-1:0] LAST_BIN  = BW'(N - 1);

    bank_state_e    bank_state_q [2];
    bank_state_e    bank_state_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  pair_cnt_q, pair_cnt_d;
    logic [BW-1:0]  rd_cnt_q, rd_cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           out_first_q, out_first_d;
    logic           out_last_q, out_last_d;
    logic [W-1:0]   out_real_q, out_real_d;
    logic [W-1:0]   out_imag_q, out_imag_d;
    logic           frame_drop_q, frame_drop_d;
    logic           frame_abort_q, frame_abort_d;

    logic           wr_en;
    logic [PW-1:0]  wr_pair;
    logic [PW-1:0]  wr_bin;
    logic [1:0]     bank_wr_en;
    logic [BW-1:0]  rd_addr;
    logic [2*W-1:0] rd_data [2];
    logic [2*W-1:0] rd_word;
    bank_state_e    wr_state;
    bank_state_e    rd_state;
    logic           load;
    logic           take;

    assign wr_state   = bank_state_q[wr_ptr_q];
    assign rd_state   = bank_state_q[rd_ptr_q];
    assign wr_bin     = bitrev5(wr_pair);
    assign bank_wr_en = {wr_en & wr_ptr_q, wr_en & ~wr_ptr_q};
    assign load       = !out_valid_q || out_ready;
    assign rd_addr    = (rd_state == BANK_FULL) ? '0 : rd_cnt_q;
    assign rd_word    = rd_data[rd_ptr_q];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_reorder_bank #(.W(W)) u_bank (
            .clk      (clk),
            .wr_en    (bank_wr_en[g]),
            .wr_addr  (wr_bin),
            .wr_data0 ({inReal0, inImag0}),
            .wr_data1 ({inReal1, inImag1}),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data[g])
        );
    end

    // Write side only moves EMPTY/FILLING banks and read side only FULL/DRAINING
    // ones, so both sections may update bank_state_d in the same cycle.
    always_comb begin
        bank_state_d  = bank_state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pair_cnt_d    = pair_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        frame_drop_d  = 1'b0;
        frame_abort_d = 1'b0;
        wr_en         = 1'b0;
        wr_pair       = pair_cnt_q;
        out_valid_d   = out_valid_q;
        out_first_d   = out_first_q;
        out_last_d    = out_last_q;
        out_real_d    = out_real_q;
        out_imag_d    = out_imag_q;
        take          = 1'b0;

        if (in_valid) begin
            if (in_start) begin
                case (wr_state)
                    BANK_EMPTY: begin
                        bank_state_d[wr_ptr_q] = BANK_FILLING;
                        wr_en      = 1'b1;
                        wr_pair    = '0;
                        pair_cnt_d = PW'(1);
                    end
                    BANK_FILLING: begin
                        frame_abort_d = 1'b1;
                        wr_en         = 1'b1;
                        wr_pair       = '0;
                        pair_cnt_d    = PW'(1);
                    end
                    default: frame_drop_d = 1'b1;
                endcase
            end else if (wr_state == BANK_FILLING) begin
                wr_en = 1'b1;
                if (pair_cnt_q == LAST_PAIR) begin
                    bank_state_d[wr_ptr_q] = BANK_FULL;
                    wr_ptr_d   = ~wr_ptr_q;
                    pair_cnt_d = '0;
                end else begin
                    pair_cnt_d = pair_cnt_q + PW'(1);
                end
            end
        end

        if (load) begin
            out_valid_d = 1'b0;
            case (rd_state)
                BANK_FULL: begin
                    bank_state_d[rd_ptr_q] = BANK_DRAINING;
                    rd_cnt_d = BW'(1);
                    take     = 1'b1;
                end
                BANK_DRAINING: begin
                    take = 1'b1;
                    if (rd_cnt_q == LAST_BIN) begin
                        bank_state_d[rd_ptr_q] = BANK_EMPTY;
                        rd_ptr_d = ~rd_ptr_q;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
            if (take) begin
                out_valid_d = 1'b1;
                out_real_d  = rd_word[2*W-1:W];
                out_imag_d  = rd_word[W-1:0];
                out_first_d = (rd_addr == '0);
                out_last_d  = (rd_addr == LAST_BIN);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            pair_cnt_q      <= '0;
            rd_cnt_q        <= '0;
            out_valid_q     <= 1'b0;
            out_first_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_real_q      <= '0;
            out_imag_q      <= '0;
            frame_drop_q    <= 1'b0;
            frame_abort_q   <= 1'b0;
        end else begin
            bank_state_q    <= bank_state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            pair_cnt_q      <= pair_cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            out_valid_q     <= out_valid_d;
            out_first_q     <= out_first_d;
            out_last_q      <= out_last_d;
            out_real_q      <= out_real_d;
            out_imag_q      <= out_imag_d;
            frame_drop_q    <= frame_drop_d;
            frame_abort_q   <= frame_abort_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_first   = out_first_q;
    assign out_last    = out_last_q;
    assign outReal     = out_real_q;
    assign outImag     = out_imag_q;
    assign frame_drop  = frame_drop_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - scoreboard bench for fft_out_reorder
`timescale 1ns/1ps
module tb_fft_out_reorder;

    localparam int W  = 16;
    localparam int XW = 2 * W + 2;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid, in_start;
    logic [W-1:0] inReal0, inImag0, inReal1, inImag1;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] outReal, outImag;
    logic         out_first, out_last;
    logic         frame_drop, frame_abort;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [XW-1:0] exp_q [$];

    fft_out_reorder #(.W(W), .N(64)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .inReal0    (inReal0),
        .inImag0    (inImag0),
        .inReal1    (inReal1),
        .inImag1    (inImag1),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .outReal    (outReal),
        .outImag    (outImag),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_drop (frame_drop),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] rev5(input int i);
        logic [4:0] v;
        logic [4:0] r;
        v = 5'(i);
        for (int b = 0; b < 5; b++) r[b] = v[4-b];
        return r;
    endfunction

    function automatic logic [XW-1:0] exp_bin(input int tag, input int k);
        logic [W-1:0] re;
        re = W'(tag + k);
        return {k == 0, k == 63, re, -re};
    endfunction

    task automatic push_frame(input int tag);
        for (int k = 0; k < 64; k++) exp_q.push_back(exp_bin(tag, k));
    endtask

    task automatic drive(input logic v, input logic s, input int i, input int tag);
        logic [W-1:0] r0, r1;
        r0 = W'(tag + int'(rev5(i)));
        r1 = W'(tag + int'(rev5(i)) + 32);
        in_valid = v;
        in_start = s;
        inReal0  = r0;
        inImag0  = -r0;
        inReal1  = r1;
        inImag1  = -r1;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_input();
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; out_ready = 1'b1;
        stop_input();
        inReal0 = '0; inImag0 = '0; inReal1 = '0; inImag1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, out_first, out_last, outReal, outImag, frame_drop, frame_abort} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {out_valid, out_first, out_last, outReal, outImag, frame_drop, frame_abort});
        else pass_cnt++;
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, frame_drop, frame_abort} !== 3'b000)
            $display("FAIL idle_after_reset: got %b required 000", {out_valid, frame_drop, frame_abort});
        else pass_cnt++;
    endtask

    task automatic test_single_frame();
        int c, first_c;
        logic [XW-1:0] e;
        push_frame(0);
        for (int i = 0; i < 32; i++) drive(1'b1, i == 0, i, 0);
        stop_input();
        c = 0; first_c = -1;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                e = exp_q.pop_front();
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL single_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL single_timeout: %0d bins missing, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (first_c !== 1) $display("FAIL single_latency: first bin at cycle %0d required 1", first_c);
        else pass_cnt++;
        total_cnt++;
        if (c - first_c !== 64) $display("FAIL single_contiguous: span %0d required 64", c - first_c);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int c;
        logic stalled;
        logic [XW-1:0] e;
        push_frame(0);
        for (int i = 0; i < 32; i++) drive(1'b1, i == 0, i, 0);
        stop_input();
        c = 0; stalled = 1'b0;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk);
            if (!stalled && out_valid && outReal == W'(5)) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                e = exp_q[0];
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    total_cnt++;
                    if ({out_valid, out_first, out_last, outReal, outImag} !== {1'b1, e})
                        $display("FAIL stall_hold: got %h required %h",
                                 {out_valid, out_first, out_last, outReal, outImag}, {1'b1, e});
                    else pass_cnt++;
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL bp_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        out_ready = 1'b1;
        total_cnt++;
        if (exp_q.size() != 0 || !stalled) begin
            $display("FAIL bp_complete: %0d bins missing, stall seen %0d, required 0 and 1", exp_q.size(), stalled);
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c, first_c, last_c, drop_cnt, extra;
        logic [XW-1:0] e;
        push_frame(100);
        push_frame(200);
        c = 0; first_c = -1; last_c = -1; drop_cnt = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < 32; i++) begin
                        drive(1'b1, i == 0, i, 100 * (f + 1));
                        if (f == 2 && i < 2) begin
                            total_cnt++;
                            if (frame_drop !== (i == 0))
                                $display("FAIL drop_pulse_%0d: got %b required %b", i, frame_drop, i == 0);
                            else pass_cnt++;
                        end
                    end
                end
                stop_input();
            end
            begin
                while (exp_q.size() > 0 && c < 400) begin
                    @(negedge clk);
                    if (frame_drop) drop_cnt++;
                    if (out_valid && out_ready) begin
                        if (first_c < 0) first_c = c;
                        last_c = c;
                        e = exp_q.pop_front();
                        total_cnt++;
                        if ({out_first, out_last, outReal, outImag} !== e)
                            $display("FAIL b2b_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                        else pass_cnt++;
                    end
                    c++;
                end
            end
        join
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_timeout: %0d bins missing, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (last_c - first_c !== 127) $display("FAIL b2b_no_bubble: span %0d required 127", last_c - first_c);
        else pass_cnt++;
        total_cnt++;
        if (drop_cnt !== 1) $display("FAIL b2b_drop_count: got %0d required 1", drop_cnt);
        else pass_cnt++;
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL b2b_dropped_frame_output: got %0d valid cycles required 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_mid_fill_restart();
        int c, extra, abort_cnt;
        logic [XW-1:0] e;
        push_frame(7);
        abort_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i == 0, i, 50);
            if (frame_abort) abort_cnt++;
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, i == 0, i, 7);
            if (frame_abort) abort_cnt++;
            if (i < 2) begin
                total_cnt++;
                if (frame_abort !== (i == 0))
                    $display("FAIL abort_pulse_%0d: got %b required %b", i, frame_abort, i == 0);
                else pass_cnt++;
            end
        end
        stop_input();
        total_cnt++;
        if (abort_cnt !== 1) $display("FAIL abort_count: got %0d required 1", abort_cnt);
        else pass_cnt++;
        c = 0;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL restart_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL restart_timeout: %0d bins missing, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL restart_single_frame: got %0d extra valid cycles required 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_in_valid_gaps();
        int c, first_c, i, cyc;
        logic [XW-1:0] e;
        push_frame(0);
        i = 0; cyc = 0;
        while (i < 32) begin
            if (cyc % 3 == 2) drive(1'b0, 1'b0, int'($urandom_range(0, 31)), 555);
            else begin
                drive(1'b1, i == 0, i, 0);
                i++;
            end
            cyc++;
        end
        stop_input();
        c = 0; first_c = -1;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                e = exp_q.pop_front();
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL gap_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL gap_timeout: %0d bins missing, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (first_c !== 1) $display("FAIL gap_latency: first bin at cycle %0d required 1", first_c);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int c, popped, extra;
        logic [XW-1:0] e;
        push_frame(0);
        for (int i = 0; i < 32; i++) drive(1'b1, i == 0, i, 0);
        stop_input();
        c = 0; popped = 0;
        while (popped < 20 && c < 300) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                popped++;
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL pre_reset_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        @(negedge clk);
        total_cnt++;
        if ({out_valid, outReal} !== {1'b1, exp_q[0][2*W-1:W]})
            $display("FAIL bin20_presented: got %h required %h", {out_valid, outReal}, {1'b1, exp_q[0][2*W-1:W]});
        else pass_cnt++;
        #2 nrst = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_first, out_last, outReal, outImag} !== '0)
            $display("FAIL async_reset_clear: got %h required 0", {out_valid, out_first, out_last, outReal, outImag});
        else pass_cnt++;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL post_reset_silent: got %0d valid cycles required 0", extra);
        else pass_cnt++;
        @(posedge clk);
        #1;
        push_frame(0);
        for (int i = 0; i < 32; i++) drive(1'b1, i == 0, i, 0);
        stop_input();
        c = 0;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total_cnt++;
                if ({out_first, out_last, outReal, outImag} !== e)
                    $display("FAIL post_reset_bin: got %h required %h", {out_first, out_last, outReal, outImag}, e);
                else pass_cnt++;
            end
            c++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL post_reset_timeout: %0d bins missing, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_mid_fill_restart();
        test_in_valid_gaps();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
